data_memory_responder: RTL
==========================

// Module: data_memory_responder
// PURPOSE
//   Responder side of the CPU data-memory interface. Accepts load/store requests
//   from the datapath (address = aluout, store data = writedata) and returns readdata.
//   Handshake: req/ack with a configurable access latency, so the core can be stalled.
//   Sits between the single-cycle core's memory port and a word-organised on-chip RAM.
// PARAMETERS
//   DEPTH_WORDS  1024            number of 32-bit words; power of two, >= 2
//   LATENCY      2               wait cycles between acceptance and completion; >= 1
//   BASE_ADDR    32'h1001_0000   byte address of word 0; word aligned
// PORTS
//   clk    in   1   clock, all state updates on rising edge
//   reset  in   1   asynchronous, active-high; clears FSM and all outputs
//   req    in   1   request valid; held high by requester until ack
//   we     in   1   1 = store, 0 = load; sampled with req
//   addr   in   32  byte address; sampled with req
//   wdata  in   32  store data; sampled with req
//   rdata  out  32  load data; registered, valid when ack=1 and we was 0
//   ack    out  1   completion pulse, exactly one cycle per accepted request
//   busy   out  1   1 while a request is in flight (state != IDLE)
//   err    out  1   access fault; valid only together with ack
// BEHAVIOUR
//   Reset: state=IDLE, ack=0, busy=0, err=0, rdata=0, counter=0. RAM contents are not
//     cleared. Reset mid-access aborts the access; a pending store is NOT written.
//   FSM states: IDLE, WAIT, DONE.
//     IDLE: if req=1 at edge -> latch we/addr/wdata, cnt<=LATENCY-1, go WAIT.
//     WAIT: cnt!=0 -> cnt<=cnt-1; cnt==0 -> perform access, go DONE.
//     DONE: ack=1, err as computed; next edge -> IDLE unconditionally.
//   Latency: req seen in cycle 0 (IDLE) -> ack high in cycle LATENCY+1.
//   req is ignored in WAIT and DONE; a request still high in the cycle after ack
//     (back in IDLE) is accepted as a new request. Minimum spacing: LATENCY+2 cycles.
//   Fault: err=1 if addr[1:0]!=0 or addr<BASE_ADDR or addr>=BASE_ADDR+4*DEPTH_WORDS
//     (unsigned, 33-bit compare, no wrap-around). Faulting store: RAM unchanged.
//     Faulting load: rdata<=0.
//   Word index = (addr-BASE_ADDR)>>2, width log2(DEPTH_WORDS).
//   Access at WAIT->DONE edge: store writes RAM[idx]<=wdata, rdata unchanged;
//     load sets rdata<=RAM[idx]. Store then load to same word returns the new data.
//   rdata holds its value until the next completed load (or reset).
//   ack, err, busy are registered outputs (decoded from state regs), no comb path from req.
//   Latched addr/we/wdata are stable during WAIT; input changes there have no effect.
// TESTING
//   1 Store 32'hDEADBEEF to BASE+8, then load BASE+8 -> ack in cycle 3 of each
//     request (LATENCY=2), err=0, rdata=32'hDEADBEEF; busy=1 cycles 1-3.
//   2 Load BASE+2 (misaligned) -> ack with err=1, rdata=0; later load BASE+0 gives
//     its previous contents, no side effect.
//   3 Store 32'h1234 to BASE+4*DEPTH_WORDS and to BASE-4 -> err=1 each; load of
//     last word BASE+4*(DEPTH_WORDS-1) returns its earlier value, not 32'h1234.
//   4 req held high continuously with a new addr after each ack -> exactly one ack
//     per request, second request accepted the cycle after first ack, no double write.
//   5 Assert reset during WAIT of a store of 32'hA5A5A5A5 to BASE+16 -> ack/busy/err/
//     rdata drop to 0 immediately (no clock edge); later load BASE+16 returns old value.
//   6 LATENCY=1 build: store/load pair -> ack in cycle 2; load of last valid word OK.

Source files
------------

// File: rtl/data_memory_responder.sv
// Purpose : responder for the core's data-memory port; serves load/store requests from a word RAM.
// Latency : request accepted in IDLE completes LATENCY+1 cycles later with a one-cycle ack pulse.
// Backpressure: busy while a request is in flight; req is ignored until the FSM returns to IDLE.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   req, we           request valid (held until ack), 1 = store / 0 = load
//   addr, wdata       byte address and store data, captured when the request is accepted
//   rdata             registered load data, updated only by a completed load
//   ack, busy, err    completion pulse, in-flight flag, access fault (meaningful with ack)
module data_memory_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  // Counter only ever holds LATENCY-1 down to 0.
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  // Window bounds widened to 33 bits so a window ending at 4 GiB does not wrap.
  localparam logic [32:0] ADDR_LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] ADDR_HI = ADDR_LO + (33'(DEPTH_WORDS) * 33'd4);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             lat_we;
  logic [31:0]      lat_addr;
  logic [31:0]      lat_wdata;
  logic             err_q;

  logic [31:0]      mem [DEPTH_WORDS];

  // Fault and word index are derived from the captured address only, so input
  // activity while waiting cannot disturb the access.
  logic [32:0]      addr_ext;
  logic [31:0]      addr_off;
  logic [IDX_W-1:0] idx;
  logic             fault;
  logic             access;
  logic             unused_off_bits;

  assign addr_ext        = {1'b0, lat_addr};
  assign addr_off        = lat_addr - BASE_ADDR;
  assign idx             = addr_off[IDX_W+1:2];
  assign unused_off_bits = ^{addr_off[31:IDX_W+2], addr_off[1:0]};

  assign fault = (lat_addr[1:0] != 2'b00) ||
                 (addr_ext < ADDR_LO)     ||
                 (addr_ext >= ADDR_HI);

  // The single cycle in which the RAM is touched: last wait cycle.
  assign access = (state == S_WAIT) && (cnt == '0);

  // Status outputs decode straight from flops, so reset clears them at once
  // and there is no combinational path from req.
  assign ack  = (state == S_DONE);
  assign busy = (state != S_IDLE);
  assign err  = err_q;

  // RAM contents survive reset. During reset the FSM is forced to IDLE, so an
  // interrupted store never reaches this write.
  always_ff @(posedge clk) begin
    if (!reset && access && lat_we && !fault) begin
      mem[idx] <= lat_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      err_q     <= 1'b0;
      rdata     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            lat_we    <= we;
            lat_addr  <= addr;
            lat_wdata <= wdata;
            cnt       <= CNT_W'(LATENCY - 1);
            state     <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= S_DONE;
            err_q <= fault;
            // Stores leave rdata alone; a faulting load returns zero.
            if (!lat_we) begin
              rdata <= fault ? 32'd0 : mem[idx];
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          err_q <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          err_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
